// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction-fetch front end. Owns the fetch PC, presents it to instruction
// memory, and buffers each returned instruction together with its PC+4 in a
// small FIFO that feeds the IF/ID register. Memory wait states and decode
// stalls are decoupled by the FIFO. A redirect flushes every buffered entry
// and restarts fetch at the (word-aligned) target.
//
// Parameters
//   DEPTH     number of queue entries (power of two, >= 2)
//   RESET_PC  fetch PC loaded by reset
//
// Ports
//   Clk              in   pipeline clock, rising edge
//   Reset            in   asynchronous, active-high
//   Redirect         in   flush the queue and load RedirectAddress as the PC
//   RedirectAddress  in   new fetch target, bits [1:0] forced to zero
//   IMemAddress      out  fetch PC (straight from the PC register)
//   IMemInstruction  in   instruction word at IMemAddress
//   IMemValid        in   IMemInstruction is valid this cycle
//   IDReady          in   decode accepts the head entry this cycle
//   IDValid          out  head entry valid
//   IDInstruction    out  head instruction, zero (NOP) when !IDValid
//   IDPCAddResult    out  head entry's PC+4, zero when !IDValid
//   Count            out  number of occupied entries
//
// Optional feature
//   FETCH_BYPASS_EN  when defined, an empty queue forwards the memory word to
//                    the ID outputs in the same cycle; if decode accepts it
//                    the word is never written into storage.

module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Redirect,
  input  logic [31:0]                RedirectAddress,
  output logic [31:0]                IMemAddress,
  input  logic [31:0]                IMemInstruction,
  input  logic                       IMemValid,
  input  logic                       IDReady,
  output logic                       IDValid,
  output logic [31:0]                IDInstruction,
  output logic [31:0]                IDPCAddResult,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Each entry is {PC+4, instruction}.
  logic [63:0] storage [DEPTH];

  logic [31:0] pcPlus4;
  logic [31:0] redirectTarget;
  logic [63:0] headEntry;
  logic        storeValid;
  logic        storePop;
  logic        bypassValid;
  logic        bypassTake;
  logic        push;

  assign pcPlus4        = pc_q + 32'd4;
  // Masking (rather than slicing) keeps the low address bits formally used.
  assign redirectTarget = RedirectAddress & ~32'h3;
  assign headEntry      = storage[rdPtr_q];
  assign storeValid     = (count_q != '0);
  assign storePop       = storeValid && IDReady;

`ifdef FETCH_BYPASS_EN
  // Only an empty queue forwards the live memory word; otherwise ordering
  // would be broken by skipping older buffered entries.
  assign bypassValid = !storeValid && IMemValid && !Redirect;
`else
  assign bypassValid = 1'b0;
`endif
  assign bypassTake = bypassValid && IDReady;

  // A forwarded-and-consumed word still advances the PC but is not stored.
  // Pushing into a full queue is allowed when the head leaves the same cycle.
  assign push = IMemValid && !Redirect && !bypassTake &&
                ((count_q < DEPTH_C) || storePop);

  // Next-state logic. Redirect wins over everything, including a same-cycle
  // pop, which is simply dropped along with the rest of the queue.
  always_comb begin
    pc_d    = pc_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (Redirect) begin
      pc_d    = redirectTarget;
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push || bypassTake) begin
        pc_d = pcPlus4;
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (storePop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      if (push && !storePop) begin
        count_d = count_q + CNT_W'(1);
      end else if (storePop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: it is only visible through a nonzero count.
  always_ff @(posedge Clk) begin
    if (push) begin
      storage[wrPtr_q] <= {pcPlus4, IMemInstruction};
    end
  end

  assign IMemAddress = pc_q;
  assign Count       = count_q;

`ifdef FETCH_BYPASS_EN
  always_comb begin
    IDValid       = 1'b0;
    IDInstruction = 32'h0;
    IDPCAddResult = 32'h0;
    if (storeValid) begin
      IDValid       = 1'b1;
      IDInstruction = headEntry[31:0];
      IDPCAddResult = headEntry[63:32];
    end else if (bypassValid) begin
      IDValid       = 1'b1;
      IDInstruction = IMemInstruction;
      IDPCAddResult = pcPlus4;
    end
  end
`else
  always_comb begin
    IDValid       = 1'b0;
    IDInstruction = 32'h0;
    IDPCAddResult = 32'h0;
    if (storeValid) begin
      IDValid       = 1'b1;
      IDInstruction = headEntry[31:0];
      IDPCAddResult = headEntry[63:32];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Testbench for fetch_prefetch_queue (DEPTH=4, RESET_PC=32'h40).
// The reference model is a plain queue of {PC+4, instruction} entries plus a
// PC variable. Entries that decode should receive are pushed into a
// scoreboard queue; an independent monitor pops them on every handshake.

module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam int          CNT_W    = $clog2(DEPTH + 1);

  logic             Clk;
  logic             Reset;
  logic             Redirect;
  logic [31:0]      RedirectAddress;
  logic [31:0]      IMemAddress;
  logic [31:0]      IMemInstruction;
  logic             IMemValid;
  logic             IDReady;
  logic             IDValid;
  logic [31:0]      IDInstruction;
  logic [31:0]      IDPCAddResult;
  logic [CNT_W-1:0] Count;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] refPc;
  logic [63:0] refFifo [$];
  logic [63:0] expQ [$];

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Redirect        (Redirect),
    .RedirectAddress (RedirectAddress),
    .IMemAddress     (IMemAddress),
    .IMemInstruction (IMemInstruction),
    .IMemValid       (IMemValid),
    .IDReady         (IDReady),
    .IDValid         (IDValid),
    .IDInstruction   (IDInstruction),
    .IDPCAddResult   (IDPCAddResult),
    .Count           (Count)
  );

  // Free-running clock, period 10.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // One comparison; shared by the driver and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model of one clock cycle, written from the queue's behavioural rules.
  task automatic modelStep(input logic redir, input logic [31:0] raddr,
                           input logic mv, input logic rdy,
                           input logic [31:0] instr);
    int  sizeBefore;
    logic popOk;
    logic bypassOk;
    if (redir) begin
      refFifo.delete();
      refPc = {raddr[31:2], 2'b00};
    end else begin
      sizeBefore = refFifo.size();
      popOk      = (sizeBefore > 0) && rdy;
`ifdef FETCH_BYPASS_EN
      bypassOk   = (sizeBefore == 0) && mv;
`else
      bypassOk   = 1'b0;
`endif
      if (popOk) expQ.push_back(refFifo.pop_front());
      if (bypassOk && rdy) begin
        expQ.push_back({refPc + 32'd4, instr});
        refPc = refPc + 32'd4;
      end else if (mv && (sizeBefore < DEPTH || popOk)) begin
        refFifo.push_back({refPc + 32'd4, instr});
        refPc = refPc + 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, check state-visible outputs, advance the model.
  task automatic applyStimulus(input logic redir, input logic [31:0] raddr,
                               input logic mv, input logic rdy);
    logic expValid;
    @(negedge Clk);
    Redirect        = redir;
    RedirectAddress = raddr;
    IMemValid       = mv;
    IDReady         = rdy;
    IMemInstruction = $urandom;
    #1;
    expValid = (refFifo.size() != 0);
`ifdef FETCH_BYPASS_EN
    if (refFifo.size() == 0 && mv && !redir) expValid = 1'b1;
`endif
    checkOutput("imemAddress", IMemAddress, refPc);
    checkOutput("count", 32'(Count), 32'(refFifo.size()));
    checkOutput("idValid", 32'(IDValid), 32'(expValid));
    if (refFifo.size() != 0) begin
      checkOutput("headInstrView", IDInstruction, refFifo[0][31:0]);
    end
    modelStep(redir, raddr, mv, rdy, IMemInstruction);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic resetMidStream();
    @(negedge Clk);
    Redirect  = 1'b0;
    IMemValid = 1'b0;
    IDReady   = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    checkOutput("asyncRstAddr", IMemAddress, RESET_PC);
    checkOutput("asyncRstCount", 32'(Count), 32'd0);
    checkOutput("asyncRstValid", 32'(IDValid), 32'd0);
    checkOutput("asyncRstInstr", IDInstruction, 32'd0);
    checkOutput("asyncRstPc4", IDPCAddResult, 32'd0);
    refFifo.delete();
    expQ.delete();
    refPc = RESET_PC;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever decode takes an entry.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge Clk);
      #2;
      if (!Reset) begin
        if (IDValid && IDReady && !Redirect) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedHandshake: got pc4 %h, expected none at %0t",
                     IDPCAddResult, $time);
          end else begin
            exp = expQ.pop_front();
            checkOutput("handshakeInstr", IDInstruction, exp[31:0]);
            checkOutput("handshakePc4", IDPCAddResult, exp[63:32]);
          end
        end else if (!IDValid) begin
          checkOutput("emptyInstr", IDInstruction, 32'd0);
          checkOutput("emptyPc4", IDPCAddResult, 32'd0);
        end
      end
    end
  end

  initial begin
    Reset           = 1'b1;
    Redirect        = 1'b0;
    RedirectAddress = 32'h0;
    IMemInstruction = 32'h0;
    IMemValid       = 1'b0;
    IDReady         = 1'b0;
    refPc           = RESET_PC;
    #1;
    checkOutput("rstAddr", IMemAddress, RESET_PC);
    checkOutput("rstValid", 32'(IDValid), 32'd0);
    checkOutput("rstInstr", IDInstruction, 32'd0);
    checkOutput("rstPc4", IDPCAddResult, 32'd0);
    checkOutput("rstCount", 32'(Count), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    $display("[TB] streaming from reset PC");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] fill to full then drain");
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] redirect with three entries queued");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_1003, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] redirect with pop while full");
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] memory wait states");
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    end

    $display("[TB] PC wrap at top of address space");
    applyStimulus(1'b1, 32'hFFFF_FFF4, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    resetMidStream();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 5), $urandom,
                    ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
    end

    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge Clk);
    #3;
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction-fetch front end of the 5-stage pipeline: owns the fetch PC, drives the instruction-memory address, and buffers fetched instructions with their PC+4 in a small FIFO ahead of the IF/ID register. Decouples instruction-memory wait states from decode stalls. Accepts a redirect (branch/jump target from MEM) that flushes all buffered work and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Redirect  in  1  flush queue and load RedirectAddress into the fetch PC.
- RedirectAddress  in  32  new fetch target; bits [1:0] ignored (forced 0).
- IMemAddress  out  32  current fetch PC to instruction memory.
- IMemInstruction  in  32  instruction word at IMemAddress.
- IMemValid  in  1  IMemInstruction valid this cycle (low = wait state).
- IDReady  in  1  decode accepts the head entry this cycle.
- IDValid  out  1  head entry valid.
- IDInstruction  out  32  head instruction; 32'h0 (NOP) when !IDValid.
- IDPCAddResult  out  32  head entry's PC+4; 32'h0 when !IDValid.
- Count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- State: fetch PC, DEPTH×64-bit storage {PC+4, instruction}, read/write pointers ($clog2(DEPTH) bits, natural wrap), count.
- Pop = IDValid && IDReady. Push = IMemValid && !Redirect && (Count < DEPTH || pop).
- Push: write {PC+4, IMemInstruction} at write pointer, PC ← PC+4 (mod 2^32, wraps silently).
- No push: PC holds.
- Count update: +1 push only, −1 pop only, unchanged on both or neither.
- Redirect (priority over everything): pointers and Count ← 0, PC ← {RedirectAddress[31:2],2'b00}; any same-cycle pop is discarded, no push.
- Full (Count==DEPTH) without pop: push suppressed, IMemAddress stable until space frees.
- Empty: IDValid=0, IDInstruction=0, IDPCAddResult=0; IDReady ignored.
- IDValid = (Count != 0); head outputs read from storage at read pointer.

## Timing
- Reset values: PC=RESET_PC, IMemAddress=RESET_PC, Count=0, IDValid=0, IDInstruction=0, IDPCAddResult=0, pointers 0.
- IMemAddress is the PC register output directly (no combinational path from inputs).
- Fetch-to-decode latency: instruction pushed at edge N is visible on ID outputs in the cycle after edge N (1 cycle) when queue was empty.
- Steady state with IDReady=1 and IMemValid=1: one instruction per cycle, Count holds at 1.
- Redirect asserted in cycle N: IMemAddress = target from cycle N+1; first target instruction on ID outputs in cycle N+2 (N+1 with bypass, below).
- Reset asserted mid-stream: all state cleared immediately (asynchronous), outputs to reset values without waiting for Clk.

## Configuration
- FETCH_BYPASS_EN defined: when Count==0 and IMemValid && !Redirect, IMemInstruction/PC+4 drive ID outputs combinationally with IDValid=1; if IDReady is also high the word is consumed without being written (no push, PC still advances). Zero-cycle fetch-to-decode latency when empty.
- Not defined: ID outputs come only from storage; 1-cycle latency as above; no combinational path from IMem inputs to ID outputs.

## Test plan
- Reset with RESET_PC=32'h40: IMemAddress=32'h40, IDValid=0, IDInstruction=0, Count=0; release, IMemValid=1, IDReady=1 → ID outputs stream 32'h44,32'h48,… as IDPCAddResult with matching words.
- IDReady=0, IMemValid=1 for 6 cycles from empty → Count saturates at 4, IMemAddress frozen at RESET_PC+16; IDReady=1 → entries drain in order, no loss or duplication.
- Redirect to 32'h0000_1003 with 3 entries queued → next cycle Count=0, IDValid=0, IMemAddress=32'h1000; next word carries IDPCAddResult=32'h1004.
- Redirect and IDReady in same cycle with Count=DEPTH → pop discarded, Count=0, nothing pushed.
- IMemValid toggling 1,0,0,1 with IDReady=1 → PC advances only on valid cycles; IDValid gaps match wait states.
- FETCH_BYPASS_EN on, empty, IMemValid=1, IDReady=1 → IDValid=1 same cycle, Count remains 0; PC near 32'hFFFF_FFFC wraps to 0.
